// File: rtl/tank_pkg.sv
// Types and geometry constants shared by the bullet, color-mapper and tank-motion blocks.
package tank_pkg;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        RIGHT = 2'b01,
        DOWN  = 2'b10,
        LEFT  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        FLY      = 2'b01,
        COOLDOWN = 2'b10
    } bullet_state_t;

    localparam logic [9:0] PARK = 10'h3FF;

    localparam int SCREEN_W        = 640;
    localparam int SCREEN_H        = 480;
    localparam int TANK_W          = 70;
    localparam int TANK_H          = 50;
    localparam int SPEED           = 4;
    localparam int COOLDOWN_FRAMES = 30;

    // One guard bit over the 11-bit signed coordinate range, so box edges near 1023 cannot wrap.
    typedef logic signed [11:0] coord_t;

    function automatic coord_t to_coord(input logic [9:0] v);
        return $signed({2'b00, v});
    endfunction

    function automatic logic on_screen(input coord_t x, input coord_t y);
        return (x >= 12'sd0) && (x <= coord_t'(SCREEN_W - 1)) &&
               (y >= 12'sd0) && (y <= coord_t'(SCREEN_H - 1));
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], async_in};
            pulse  <= sync_q[1] & ~sync_q[2];
        end
    end

endmodule

// File: rtl/bullet_controller.sv
// Per-tank bullet engine: launch from the muzzle, advance per frame, hit test, off-screen retire, reload cooldown.
module bullet_controller
    import tank_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       enable,
    input  logic       fire,
    input  logic [1:0] dir,
    input  logic [9:0] TankX_own,
    input  logic [9:0] TankY_own,
    input  logic [9:0] TankX_opp,
    input  logic [9:0] TankY_opp,
    output logic [9:0] BulletX,
    output logic [9:0] BulletY,
    output logic       bullet_active,
    output logic       ready,
    output logic       hit
);

    localparam logic [4:0] CNT_LOAD = 5'(COOLDOWN_FRAMES);
    localparam coord_t     STEP     = coord_t'(SPEED);

    logic frame_tick, fire_edge;

    sync_edge u_frame_sync (.clk(Clk), .rst_n(Reset), .async_in(frame_clk), .pulse(frame_tick));
    sync_edge u_fire_sync  (.clk(Clk), .rst_n(Reset), .async_in(fire),      .pulse(fire_edge));

    bullet_state_t state, state_nxt;
    dir_t          fly_dir, fly_dir_nxt;
    logic [9:0]    x_nxt, y_nxt;
    logic [4:0]    cnt, cnt_nxt;
    logic          hit_nxt;

    coord_t own_x, own_y, opp_x, opp_y, cur_x, cur_y;
    coord_t mz_x, mz_y, nx, ny;
    logic   in_box;

    assign own_x = to_coord(TankX_own);
    assign own_y = to_coord(TankY_own);
    assign opp_x = to_coord(TankX_opp);
    assign opp_y = to_coord(TankY_opp);
    assign cur_x = to_coord(BulletX);
    assign cur_y = to_coord(BulletY);

    always_comb begin
        mz_x = own_x;
        mz_y = own_y;
        unique case (dir_t'(dir))
            UP:      begin mz_x = own_x + 12'sd35; mz_y = own_y - 12'sd5;  end
            RIGHT:   begin mz_x = own_x + 12'sd75; mz_y = own_y + 12'sd25; end
            DOWN:    begin mz_x = own_x + 12'sd35; mz_y = own_y + 12'sd55; end
            default: begin mz_x = own_x - 12'sd5;  mz_y = own_y + 12'sd25; end
        endcase
    end

    always_comb begin
        nx = cur_x;
        ny = cur_y;
        unique case (fly_dir)
            UP:      ny = cur_y - STEP;
            RIGHT:   nx = cur_x + STEP;
            DOWN:    ny = cur_y + STEP;
            default: nx = cur_x - STEP;
        endcase
    end

    // Only consumed on frame_tick, so opponent moves mid-frame have no effect.
    assign in_box = (nx >= opp_x) && (nx <= opp_x + coord_t'(TANK_W)) &&
                    (ny >= opp_y) && (ny <= opp_y + coord_t'(TANK_H));

    always_comb begin
        state_nxt   = state;
        fly_dir_nxt = fly_dir;
        x_nxt       = BulletX;
        y_nxt       = BulletY;
        cnt_nxt     = cnt;
        hit_nxt     = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            x_nxt     = PARK;
            y_nxt     = PARK;
            cnt_nxt   = 5'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fire_edge) begin
                        fly_dir_nxt = dir_t'(dir);
                        if (on_screen(mz_x, mz_y)) begin
                            state_nxt = FLY;
                            x_nxt     = mz_x[9:0];
                            y_nxt     = mz_y[9:0];
                        end else begin
                            state_nxt = COOLDOWN;
                            cnt_nxt   = CNT_LOAD;
                        end
                    end
                end
                FLY: begin
                    if (frame_tick) begin
                        if (in_box || !on_screen(nx, ny)) begin
                            hit_nxt   = in_box;
                            state_nxt = COOLDOWN;
                            x_nxt     = PARK;
                            y_nxt     = PARK;
                            cnt_nxt   = CNT_LOAD;
                        end else begin
                            x_nxt = nx[9:0];
                            y_nxt = ny[9:0];
                        end
                    end
                end
                COOLDOWN: begin
                    if (frame_tick) begin
                        if (cnt <= 5'd1) begin
                            state_nxt = IDLE;
                            cnt_nxt   = 5'd0;
                        end else begin
                            cnt_nxt = cnt - 5'd1;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    x_nxt     = PARK;
                    y_nxt     = PARK;
                    cnt_nxt   = 5'd0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            fly_dir <= UP;
            BulletX <= PARK;
            BulletY <= PARK;
            cnt     <= 5'd0;
            hit     <= 1'b0;
        end else begin
            state   <= state_nxt;
            fly_dir <= fly_dir_nxt;
            BulletX <= x_nxt;
            BulletY <= y_nxt;
            cnt     <= cnt_nxt;
            hit     <= hit_nxt;
        end
    end

    assign bullet_active = (state == FLY);
    assign ready         = (state == IDLE) && enable;

endmodule

// File: tb/tb_bullet_controller.sv
// Directed bench for bullet_controller: launch, flight, hit, off-screen, cooldown, abort, async reset.
module tb_bullet_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       enable = 1'b0;
    logic       fire = 1'b0;
    logic [1:0] dir = 2'b01;
    logic [9:0] own_x = 10'd100, own_y = 10'd200;
    logic [9:0] opp_x = 10'd400, opp_y = 10'd400;
    logic [9:0] bullet_x, bullet_y;
    logic       bullet_active, ready, hit;

    int checks = 0;
    int failures = 0;
    int hit_pulses = 0;

    bullet_controller dut (
        .Clk(clk), .Reset(rst_n), .frame_clk(frame_clk), .enable(enable), .fire(fire),
        .dir(dir), .TankX_own(own_x), .TankY_own(own_y), .TankX_opp(opp_x), .TankY_opp(opp_y),
        .BulletX(bullet_x), .BulletY(bullet_y), .bullet_active(bullet_active),
        .ready(ready), .hit(hit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (hit === 1'b1) hit_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick_rise();
        @(negedge clk) frame_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic tick_fall();
        frame_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick_rise();
            tick_fall();
        end
    endtask

    task automatic press_fire();
        @(negedge clk) fire = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic release_fire();
        fire = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_x", bullet_x, 10'h3FF);
        chk("rst_y", bullet_y, 10'h3FF);
        chk("rst_active", bullet_active, 1'b0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_hit", hit, 1'b0);
        @(negedge clk) begin rst_n = 1'b1; enable = 1'b1; end
        @(negedge clk);
        chk("ready_after_rst", ready, 1'b1);

        // launch right from (100,200): muzzle (175,225)
        @(negedge clk) fire = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_launch_active", bullet_active, 1'b0);
        @(negedge clk);
        chk("launch_active", bullet_active, 1'b1);
        chk("launch_x", bullet_x, 10'd175);
        chk("launch_y", bullet_y, 10'd225);
        chk("launch_ready", ready, 1'b0);
        release_fire();
        tick(3);
        chk("move3_x", bullet_x, 10'd187);
        chk("move3_y", bullet_y, 10'd225);
        tick(10);
        chk("move13_x", bullet_x, 10'd227);

        // hit: opponent box x 300..370, y 200..250
        opp_x = 10'd300; opp_y = 10'd200;
        tick(18);
        chk("prehit_x", bullet_x, 10'd299);
        chk("prehit_active", bullet_active, 1'b1);
        chk("prehit_pulses", hit_pulses, 0);
        tick_rise();
        chk("hit_pulse", hit, 1'b1);
        chk("hit_park_x", bullet_x, 10'h3FF);
        chk("hit_park_y", bullet_y, 10'h3FF);
        chk("hit_active", bullet_active, 1'b0);
        @(negedge clk);
        chk("hit_one_clk", hit, 1'b0);
        tick_fall();

        // cooldown with fire held: no autofire, re-arm after 30 ticks
        @(negedge clk) fire = 1'b1;
        tick(29);
        chk("cd29_ready", ready, 1'b0);
        chk("cd29_active", bullet_active, 1'b0);
        tick(1);
        chk("cd30_ready", ready, 1'b1);
        repeat (8) @(negedge clk);
        chk("held_no_autofire", bullet_active, 1'b0);
        chk("cd_hit_once", hit_pulses, 1);
        release_fire();
        press_fire();
        chk("refire_active", bullet_active, 1'b1);
        chk("refire_x", bullet_x, 10'd175);

        // abort during flight
        @(negedge clk) enable = 1'b0;
        @(negedge clk);
        chk("abort_x", bullet_x, 10'h3FF);
        chk("abort_active", bullet_active, 1'b0);
        chk("abort_ready", ready, 1'b0);
        chk("abort_hit", hit, 1'b0);
        release_fire();
        enable = 1'b1;
        @(negedge clk);
        chk("abort_rearm", ready, 1'b1);

        // off-screen: up from y=8 launches at (135,3), first tick gives y=-1
        dir = 2'b00; own_x = 10'd100; own_y = 10'd8; opp_x = 10'd400; opp_y = 10'd400;
        press_fire();
        chk("up_launch_x", bullet_x, 10'd135);
        chk("up_launch_y", bullet_y, 10'd3);
        release_fire();
        tick(1);
        chk("off_park_y", bullet_y, 10'h3FF);
        chk("off_active", bullet_active, 1'b0);
        chk("off_no_hit", hit_pulses, 1);
        tick(30);
        chk("off_rearm", ready, 1'b1);

        // muzzle off-screen (y=-3): straight to cooldown
        own_y = 10'd2;
        press_fire();
        chk("muzzle_out_active", bullet_active, 1'b0);
        chk("muzzle_out_ready", ready, 1'b0);
        chk("muzzle_out_y", bullet_y, 10'h3FF);
        release_fire();
        chk("muzzle_out_active2", bullet_active, 1'b0);
        tick(30);
        chk("muzzle_out_rearm", ready, 1'b1);

        // hit and off-screen on the same tick: hit wins
        dir = 2'b01; own_x = 10'd561; own_y = 10'd200; opp_x = 10'd600; opp_y = 10'd200;
        press_fire();
        chk("edge_launch_x", bullet_x, 10'd636);
        release_fire();
        tick_rise();
        chk("edge_hit", hit, 1'b1);
        chk("edge_park_x", bullet_x, 10'h3FF);
        tick_fall();
        chk("edge_hit_count", hit_pulses, 2);
        tick(30);

        // async reset mid-flight at (200,100)
        own_x = 10'd125; own_y = 10'd75; opp_x = 10'd400; opp_y = 10'd400;
        press_fire();
        chk("pre_rst_x", bullet_x, 10'd200);
        chk("pre_rst_y", bullet_y, 10'd100);
        release_fire();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_x", bullet_x, 10'h3FF);
        chk("async_rst_y", bullet_y, 10'h3FF);
        chk("async_rst_active", bullet_active, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_ready", ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
